// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared types and constants for the BCD conversion scheduler
package bcd_pkg;

  localparam int DATA_W_DEFAULT = 16;
  localparam int DIGITS_DEFAULT = 5;
  localparam logic [3:0] ADD3_THRESH = 4'd5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_STORE   = 2'd2
  } state_e;

  function automatic logic [3:0] add3(input logic [3:0] digit);
    return (digit >= ADD3_THRESH) ? digit + 4'd3 : digit;
  endfunction

endpackage

// File: rtl/bcd_dabble_core.sv
// rtl/bcd_dabble_core.sv - serial double-dabble binary to BCD converter
module bcd_dabble_core
  import bcd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   bin_in,
  output logic                done,
  output logic [DIGITS*4-1:0] bcd_out
);

  localparam int BCD_W = DIGITS * 4;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W);

  logic [BCD_W-1:0]  digits_q, digits_d, src_dig, adj;
  logic [DATA_W-1:0] shreg_q, shreg_d, src_bin;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              step_en;

  // The load cycle already performs the first step, so the result is ready
  // DATA_W-1 cycles after start and the scheduler can store it without delay.
  always_comb begin
    src_dig = start ? '0 : digits_q;
    src_bin = start ? bin_in : shreg_q;
    adj     = '0;
    for (int i = 0; i < DIGITS; i++) begin
      adj[i*4 +: 4] = add3(src_dig[i*4 +: 4]);
    end
    {digits_d, shreg_d} = {adj, src_bin} << 1;
    step_en = start || ((cnt_q != '0) && (cnt_q != LAST_CNT));
    cnt_d   = start ? CNT_W'(1) : cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      digits_q <= '0;
      shreg_q  <= '0;
      cnt_q    <= '0;
    end else if (step_en) begin
      digits_q <= digits_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
    end
  end

  assign done    = (cnt_q == LAST_CNT);
  assign bcd_out = digits_q;

endmodule

// File: rtl/bcd_conv_scheduler.sv
// rtl/bcd_conv_scheduler.sv - round-robin multi-channel binary to BCD conversion scheduler
module bcd_conv_scheduler
  import bcd_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DIGITS = DIGITS_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH-1:0]          req_valid,
  input  logic [NUM_CH*DATA_W-1:0]   req_data,
  output logic [NUM_CH-1:0]          req_ready,
  output logic [NUM_CH*DIGITS*4-1:0] bcd_out,
  output logic [NUM_CH-1:0]          bcd_valid,
  output logic                       busy
);

  localparam int BCD_W = DIGITS * 4;
  localparam int PTR_W = $clog2(NUM_CH);
  localparam logic [PTR_W:0]    NUM_CH_X = (PTR_W + 1)'(NUM_CH);
  localparam logic [PTR_W-1:0]  LAST_CH  = PTR_W'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] ONE_HOT0 = NUM_CH'(1);

  state_e                  state_q;
  logic [PTR_W-1:0]        rr_ptr_q, gnt_q, grant_idx;
  logic [PTR_W:0]          probe;
  logic                    grant_found, transfer, core_done;
  logic [BCD_W-1:0]        core_bcd;
  logic [NUM_CH*BCD_W-1:0] bcd_out_q;
  logic [NUM_CH-1:0]       bcd_valid_q;

  // Scan downwards so the valid channel closest to rr_ptr wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    probe       = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      probe = {1'b0, rr_ptr_q} + (PTR_W + 1)'(k);
      if (probe >= NUM_CH_X) probe = probe - NUM_CH_X;
      if (req_valid[probe[PTR_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = probe[PTR_W-1:0];
      end
    end
  end

  assign req_ready = ((state_q == ST_IDLE) && !reset && grant_found) ? (ONE_HOT0 << grant_idx) : '0;
  assign transfer  = |(req_valid & req_ready);
  assign busy      = (state_q != ST_IDLE);
  assign bcd_out   = bcd_out_q;
  assign bcd_valid = bcd_valid_q;

  bcd_dabble_core #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_core (
    .clk     (clk),
    .reset   (reset),
    .start   (transfer),
    .bin_in  (req_data[grant_idx*DATA_W +: DATA_W]),
    .done    (core_done),
    .bcd_out (core_bcd)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      bcd_out_q   <= '0;
      bcd_valid_q <= '0;
    end else begin
      bcd_valid_q <= '0;
      unique case (state_q)
        ST_IDLE: begin
          if (transfer) begin
            gnt_q    <= grant_idx;
            rr_ptr_q <= (grant_idx == LAST_CH) ? '0 : grant_idx + 1'b1;
            state_q  <= ST_CONVERT;
          end
        end
        ST_CONVERT: begin
          if (core_done) begin
            bcd_out_q[gnt_q*BCD_W +: BCD_W] <= core_bcd;
            bcd_valid_q <= ONE_HOT0 << gnt_q;
            state_q     <= ST_STORE;
          end
        end
        ST_STORE: state_q <= ST_IDLE;
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
